// File: rtl/debug_reply_pkg.sv
// rtl/debug_reply_pkg.sv - shared types, CRC constants and byte-wise CRC-16-CCITT helper for the debug reply framer
// Contents:
//   reply_state_t     framer FSM state encoding
//   CRC16_POLY        CRC-16-CCITT polynomial (0x1021, no reflection)
//   CRC16_INIT        CRC seed value (0xFFFF, no final XOR)
//   crc16_ccitt_byte  one-byte CRC update, MSB of the byte first
package debug_reply_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_CRC_LOAD,
        ST_CRC_SEND,
        ST_CRC_WAIT
    } reply_state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_CCITT.sv
// rtl/crc16_CCITT.sv - byte-serial CRC-16-CCITT accumulator
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset (CRC returns to seed)
//   sync_reset  synchronous return to seed; wins over crc_en
//   crc_en      fold data_in into the CRC on this edge
//   data_in     byte to fold in
//   crc_out     current CRC value
module crc16_CCITT
    import debug_reply_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sync_reset,
    input  logic        crc_en,
    input  logic [7:0]  data_in,
    output logic [15:0] crc_out
);

    logic [15:0] r_crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= CRC16_INIT;
        end else if (sync_reset) begin
            r_crc <= CRC16_INIT;
        end else if (crc_en) begin
            r_crc <= crc16_ccitt_byte(r_crc, data_in);
        end
    end

    assign crc_out = r_crc;

endmodule

// File: rtl/debug_reply_framer.sv
// rtl/debug_reply_framer.sv - frames sync + variable payload + CRC-16 and feeds the UART one byte per start/done handshake
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   reply_enable_in     frame request, honoured only while reply_ready=1
//   reply_len_in        payload byte count, clamped to MAX_PAYLOAD_BYTES
//   reply_payload       payload, byte 0 in the MSB byte
//   reply_abort         drop the current frame (and a same-cycle request in IDLE)
//   reply_ready         idle and able to accept a request
//   uart_tx_done        UART finished the current byte
//   ctl_start_uart_tx   one-cycle pulse starting a byte
//   uart_data_out       byte being transmitted, held from start through done
//   reply_done          one-cycle pulse when a frame completes
module debug_reply_framer
    import debug_reply_pkg::*;
#(
    parameter int          DATA_WIDTH        = 8,
    parameter int          MAX_PAYLOAD_BYTES = 8,
    parameter int          SYNC_BYTES        = 2,
    parameter logic [31:0] SYNC_PATTERN      = 32'h00005AA5,
    parameter int          CRC_INCLUDES_SYNC = 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   reply_enable_in,
    input  logic [$clog2(MAX_PAYLOAD_BYTES+1)-1:0] reply_len_in,
    input  logic [MAX_PAYLOAD_BYTES*8-1:0]         reply_payload,
    input  logic                                   reply_abort,
    output logic                                   reply_ready,
    input  logic                                   uart_tx_done,
    output logic                                   ctl_start_uart_tx,
    output logic [DATA_WIDTH-1:0]                  uart_data_out,
    output logic                                   reply_done
);

    localparam int LW = $clog2(MAX_PAYLOAD_BYTES + 1);
    localparam int CW = $clog2(SYNC_BYTES + MAX_PAYLOAD_BYTES + 1);
    localparam int SW = (SYNC_BYTES + MAX_PAYLOAD_BYTES) * 8;
    localparam logic [SYNC_BYTES*8-1:0] SYNC_VAL = SYNC_PATTERN[SYNC_BYTES*8-1:0];

    generate
        if (DATA_WIDTH != 8) begin : g_bad_data_width
            $error("debug_reply_framer: DATA_WIDTH must be 8");
        end
        if (MAX_PAYLOAD_BYTES < 1 || MAX_PAYLOAD_BYTES > 64) begin : g_bad_max_payload
            $error("debug_reply_framer: MAX_PAYLOAD_BYTES must be 1..64");
        end
        if (SYNC_BYTES < 1 || SYNC_BYTES > 4) begin : g_bad_sync_bytes
            $error("debug_reply_framer: SYNC_BYTES must be 1..4");
        end
    endgenerate

    reply_state_t          r_state;
    logic [SW-1:0]         r_shift;
    logic [LW-1:0]         r_len;
    logic [CW-1:0]         r_cnt;
    logic                  r_crc_idx;
    logic                  r_crc_upd;
    logic                  r_ready;
    logic                  r_start;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_data;

    logic [LW-1:0]         w_len_clamped;
    logic                  w_last_body;
    logic                  w_covered;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_crc_clear;
    logic [15:0]           w_crc;

    assign w_len_clamped = (reply_len_in > LW'(MAX_PAYLOAD_BYTES)) ? LW'(MAX_PAYLOAD_BYTES) : reply_len_in;

    // r_cnt counts bytes already handed back by the UART; the byte in flight is the last
    // header/payload byte when one more completion reaches the frame body length.
    assign w_last_body = (r_cnt + CW'(1)) == (CW'(SYNC_BYTES) + CW'(r_len));

    // Sync bytes occupy the first SYNC_BYTES counter positions.
    assign w_covered = (CRC_INCLUDES_SYNC != 0) || (r_cnt >= CW'(SYNC_BYTES));

    assign w_accept    = (r_state == ST_IDLE) && reply_enable_in && !reply_abort;
    assign w_abort     = (r_state != ST_IDLE) && reply_abort;
    assign w_crc_clear = w_accept || w_abort;

    // The CRC folds in uart_data_out during its start pulse, so r_crc_upd is
    // registered alongside r_start and only raised for covered body bytes.
    crc16_CCITT u_crc (
        .clk        (clk),
        .reset_n    (reset_n),
        .sync_reset (w_crc_clear),
        .crc_en     (r_crc_upd),
        .data_in    (r_data),
        .crc_out    (w_crc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_crc_idx <= 1'b0;
            r_crc_upd <= 1'b0;
            r_ready   <= 1'b1;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
        end else begin
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_crc_upd <= 1'b0;
            if (w_abort) begin
                // A byte already started is left for the UART to finish; its done is ignored in IDLE.
                r_state <= ST_IDLE;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_shift   <= {SYNC_VAL, reply_payload};
                            r_len     <= w_len_clamped;
                            r_cnt     <= '0;
                            r_crc_idx <= 1'b0;
                            r_ready   <= 1'b0;
                            r_state   <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        r_data    <= r_shift[SW-1 -: 8];
                        r_start   <= 1'b1;
                        r_crc_upd <= w_covered;
                        r_state   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (uart_tx_done) begin
                            r_shift <= {r_shift[SW-9:0], 8'hAA};
                            r_cnt   <= r_cnt + CW'(1);
                            r_state <= w_last_body ? ST_CRC_LOAD : ST_SEND;
                        end
                    end
                    ST_CRC_LOAD: begin
                        r_shift[SW-1 -: 16] <= w_crc;
                        r_state             <= ST_CRC_SEND;
                    end
                    ST_CRC_SEND: begin
                        r_data  <= r_shift[SW-1 -: 8];
                        r_start <= 1'b1;
                        r_state <= ST_CRC_WAIT;
                    end
                    ST_CRC_WAIT: begin
                        if (uart_tx_done) begin
                            if (r_crc_idx) begin
                                r_ready <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end else begin
                                r_shift   <= {r_shift[SW-9:0], 8'hAA};
                                r_crc_idx <= 1'b1;
                                r_state   <= ST_CRC_SEND;
                            end
                        end
                    end
                    default: begin
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign reply_ready       = r_ready;
    assign ctl_start_uart_tx = r_start;
    assign uart_data_out     = r_data;
    assign reply_done        = r_done;

endmodule

// File: tb/tb_debug_reply_framer.sv
// tb/tb_debug_reply_framer.sv - self-checking bench for debug_reply_framer
module tb_debug_reply_framer;
    import debug_reply_pkg::*;

    localparam int DLY = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic [1:0]   en, abort, done, start, ready, rdone;
    logic [7:0]   dout [2];
    logic [4:0]   len_a;
    logic [3:0]   len_b;
    logic [127:0] pl_a;
    logic [63:0]  pl_b;

    // unit 0: 16-byte payload, CRC over payload only; unit 1: 8-byte payload, CRC over sync+payload
    debug_reply_framer #(.MAX_PAYLOAD_BYTES(16), .SYNC_BYTES(2), .SYNC_PATTERN(32'h00005AA5), .CRC_INCLUDES_SYNC(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .reply_enable_in(en[0]), .reply_len_in(len_a), .reply_payload(pl_a),
        .reply_abort(abort[0]), .reply_ready(ready[0]), .uart_tx_done(done[0]), .ctl_start_uart_tx(start[0]),
        .uart_data_out(dout[0]), .reply_done(rdone[0]));

    debug_reply_framer #(.MAX_PAYLOAD_BYTES(8), .SYNC_BYTES(2), .SYNC_PATTERN(32'h00005AA5), .CRC_INCLUDES_SYNC(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .reply_enable_in(en[1]), .reply_len_in(len_b), .reply_payload(pl_b),
        .reply_abort(abort[1]), .reply_ready(ready[1]), .uart_tx_done(done[1]), .ctl_start_uart_tx(start[1]),
        .uart_data_out(dout[1]), .reply_done(rdone[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // UART model state, owned by the negedge process
    logic [7:0] log_a[$];
    logic [7:0] log_b[$];
    int         cnt [2];
    bit         busy [2];
    logic [7:0] cur [2];
    bit         prev_start [2];
    int         rdone_cnt [2];
    int         rdone_cyc [2];
    int         last_done_cyc [2];
    int         first_start_cyc [2];
    bit         ready_at_rdone [2];
    bit         ready_after_abort [2];
    int         abort_cyc [2] = '{-1, -1};
    int         stab_err = 0;
    int         ovl_err = 0;
    int         width_err = 0;

    // written by the stimulus only
    int         mark [2] = '{0, 0};
    int         abort_at [2] = '{-1, -1};

    function automatic int nlog(input int g);
        return (g == 0) ? log_a.size() : log_b.size();
    endfunction

    function automatic logic [7:0] getb(input int g, input int i);
        return (g == 0) ? log_a[i] : log_b[i];
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            done[g]  = 1'b0;
            abort[g] = 1'b0;
            if (!reset_n) begin
                busy[g]       = 1'b0;
                cnt[g]        = 0;
                prev_start[g] = 1'b0;
            end else begin
                if (start[g]) begin
                    if (prev_start[g]) width_err++;
                    if (busy[g]) ovl_err++;
                    if (nlog(g) == mark[g]) first_start_cyc[g] = cyc;
                    if (g == 0) log_a.push_back(dout[0]);
                    else        log_b.push_back(dout[1]);
                    cur[g]  = dout[g];
                    busy[g] = 1'b1;
                    cnt[g]  = DLY;
                end else if (busy[g]) begin
                    if (dout[g] !== cur[g]) stab_err++;
                    cnt[g]--;
                    if (cnt[g] == 0) begin
                        done[g]          = 1'b1;
                        busy[g]          = 1'b0;
                        last_done_cyc[g] = cyc;
                        if (nlog(g) - 1 == abort_at[g]) begin
                            abort[g]     = 1'b1;
                            abort_cyc[g] = cyc;
                        end
                    end
                end
                if (rdone[g]) begin
                    rdone_cnt[g]++;
                    rdone_cyc[g]      = cyc;
                    ready_at_rdone[g] = ready[g];
                end
                if (abort_cyc[g] >= 0 && cyc == abort_cyc[g] + 1) ready_after_abort[g] = ready[g];
                prev_start[g] = start[g];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int g, input int len_in, input logic [127:0] pl, input string nm,
                             input bit mid_en, input bit has_crc, input logic [15:0] hand_crc);
        int base, rd0, en_cyc, t, eff, maxb;
        bit inc;
        logic [7:0] eb[$];
        logic [7:0] b;
        logic [15:0] c;
        maxb = (g == 0) ? 16 : 8;
        inc  = (g == 1);
        eff  = (len_in > maxb) ? maxb : len_in;
        c    = CRC16_INIT;
        eb.push_back(8'h5A);
        eb.push_back(8'hA5);
        if (inc) begin
            c = crc16_ccitt_byte(c, 8'h5A);
            c = crc16_ccitt_byte(c, 8'hA5);
        end
        for (int i = 0; i < eff; i++) begin
            b = pl[127-8*i -: 8];
            eb.push_back(b);
            c = crc16_ccitt_byte(c, b);
        end
        if (has_crc) c = hand_crc;
        eb.push_back(c[15:8]);
        eb.push_back(c[7:0]);

        base    = nlog(g);
        rd0     = rdone_cnt[g];
        mark[g] = base;
        chk({nm, " ready_before"}, 32'(ready[g]), 32'd1);
        if (g == 0) begin len_a = 5'(len_in); pl_a = pl; end
        else        begin len_b = 4'(len_in); pl_b = pl[127:64]; end
        en[g]  = 1'b1;
        en_cyc = cyc;
        tick();
        en[g] = 1'b0;
        t = 0;
        while (rdone_cnt[g] == rd0 && t < 3000) begin
            en[g] = (mid_en && t == 30);
            tick();
            t++;
        end
        en[g] = 1'b0;
        chk({nm, " completes"}, 32'(t < 3000), 32'd1);
        repeat (10) tick();
        chk({nm, " reply_done_count"}, 32'(rdone_cnt[g] - rd0), 32'd1);
        chk({nm, " byte_count"}, 32'(nlog(g) - base), 32'(eb.size()));
        for (int i = 0; i < eb.size(); i++) begin
            if (base + i < nlog(g)) chk($sformatf("%s byte%0d", nm, i), 32'(getb(g, base + i)), 32'(eb[i]));
        end
        chk({nm, " first_start_latency"}, 32'(first_start_cyc[g] - en_cyc), 32'd2);
        chk({nm, " reply_done_latency"}, 32'(rdone_cyc[g] - last_done_cyc[g]), 32'd1);
        chk({nm, " ready_with_done"}, 32'(ready_at_rdone[g]), 32'd1);
    endtask

    typedef struct {
        int           len;
        logic [127:0] pl;
        bit           has_crc;
        logic [15:0]  crc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base, rd0, ab0, t;
        vecs[0] = '{9,  {72'h313233343536373839, 56'h0}, 1'b1, 16'h29B1};
        vecs[1] = '{0,  128'h0, 1'b1, 16'hFFFF};
        vecs[2] = '{1,  {8'h00, 120'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF}, 1'b0, 16'h0};
        vecs[3] = '{16, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 16'h0};
        vecs[4] = '{5,  {40'hDEADBEEF55, 88'h11_2233_4455_6677_8899_AA}, 1'b0, 16'h0};

        reset_n = 1'b0;
        en      = 2'b00;
        len_a   = '0;
        len_b   = '0;
        pl_a    = '0;
        pl_b    = '0;
        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset%0d ready", g), 32'(ready[g]), 32'd1);
            chk($sformatf("reset%0d start", g), 32'(start[g]), 32'd0);
            chk($sformatf("reset%0d data", g), 32'(dout[g]), 32'h00);
            chk($sformatf("reset%0d done", g), 32'(rdone[g]), 32'd0);
        end
        reset_n = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            run_frame(0, vecs[i].len, vecs[i].pl, $sformatf("vec%0d", i), 1'b0, vecs[i].has_crc, vecs[i].crc);
        end

        // length above capacity is clamped to 8 payload bytes
        run_frame(1, 15, {64'h1122334455667788, 64'hCCCC_CCCC_CCCC_CCCC}, "clamp", 1'b0, 1'b0, 16'h0);

        // request while busy is dropped
        run_frame(0, 16, 128'hA1A2A3A4A5A6A7A8_B1B2B3B4B5B6B7B8, "mid_enable", 1'b1, 1'b0, 16'h0);

        // abort coincident with uart_tx_done of payload byte 3
        base        = nlog(0);
        rd0         = rdone_cnt[0];
        ab0         = abort_cyc[0];
        abort_at[0] = base + 2 + 3;
        len_a       = 5'd9;
        pl_a        = {72'h313233343536373839, 56'h0};
        en[0]       = 1'b1;
        tick();
        en[0] = 1'b0;
        t = 0;
        while (abort_cyc[0] == ab0 && t < 2000) begin tick(); t++; end
        chk("abort fired", 32'(t < 2000), 32'd1);
        repeat (20) tick();
        abort_at[0] = -1;
        chk("abort ready_next", 32'(ready_after_abort[0]), 32'd1);
        chk("abort no_reply_done", 32'(rdone_cnt[0] - rd0), 32'd0);
        chk("abort byte_count", 32'(nlog(0) - base), 32'd6);
        run_frame(0, vecs[0].len, vecs[0].pl, "after_abort", 1'b0, 1'b1, 16'h29B1);

        // reset during CRC_WAIT
        base  = nlog(0);
        rd0   = rdone_cnt[0];
        len_a = 5'd3;
        pl_a  = {24'hC0FFEE, 104'h0};
        en[0] = 1'b1;
        tick();
        en[0] = 1'b0;
        t = 0;
        while (nlog(0) < base + 6 && t < 2000) begin tick(); t++; end
        chk("rst reached_crc", 32'(t < 2000), 32'd1);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst async ready", 32'(ready[0]), 32'd1);
        chk("rst async start", 32'(start[0]), 32'd0);
        chk("rst async data", 32'(dout[0]), 32'h00);
        chk("rst async done", 32'(rdone[0]), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("rst no_reply_done", 32'(rdone_cnt[0] - rd0), 32'd0);
        run_frame(0, vecs[0].len, vecs[0].pl, "after_reset", 1'b0, 1'b1, 16'h29B1);

        chk("data_stable_err", 32'(stab_err), 32'd0);
        chk("overlap_start_err", 32'(ovl_err), 32'd0);
        chk("start_width_err", 32'(width_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
